// File: rtl/synth_pkg.sv
// Shared types and default widths for the voice allocator and its per-voice slots.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } alloc_state_t;

  localparam int KEY_W_DEF    = 7;
  localparam int PERIOD_W_DEF = 32;
  localparam int AGE_W_DEF    = 8;

endpackage

// File: rtl/voice_slot.sv
// One oscillator slot: active flag, key, period and saturating age.
// The load command takes priority over clear, and clear takes priority over age_inc.
module voice_slot
  import synth_pkg::*;
#(
  parameter int KEY_W    = KEY_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int AGE_W    = AGE_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic                clear_i,
  input  logic                age_inc_i,
  input  logic [KEY_W-1:0]    key_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [KEY_W-1:0]    cmp_key_i,
  output logic                active_o,
  output logic [KEY_W-1:0]    key_o,
  output logic [PERIOD_W-1:0] period_o,
  output logic [AGE_W-1:0]    age_o,
  output logic                match_o
);

  logic                active_q, active_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [AGE_W-1:0]    age_q, age_d;

  always_comb begin
    active_d = active_q;
    key_d    = key_q;
    period_d = period_q;
    age_d    = age_q;
    if (load_i) begin
      active_d = 1'b1;
      key_d    = key_i;
      period_d = period_i;
      age_d    = '0;
    end else if (clear_i) begin
      // The key is kept so the front end can still see which note last used this slot.
      active_d = 1'b0;
      period_d = '0;
      age_d    = '0;
    end else if (age_inc_i && active_q && (age_q != '1)) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      key_q    <= '0;
      period_q <= '0;
      age_q    <= '0;
    end else begin
      active_q <= active_d;
      key_q    <= key_d;
      period_q <= period_d;
      age_q    <= age_d;
    end
  end

  assign active_o = active_q;
  assign key_o    = key_q;
  assign period_o = period_q;
  assign age_o    = age_q;
  assign match_o  = active_q && (key_q == cmp_key_i);

endmodule

// File: rtl/voice_allocator.sv
// Allocates note-on/note-off requests onto a fixed pool of oscillator slots,
// scanning one slot per cycle and stealing the oldest slot when the pool is full.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = KEY_W_DEF,
  parameter int PERIOD_W   = PERIOD_W_DEF,
  parameter int AGE_W      = AGE_W_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  // A request transfers on a rising edge with req_valid && req_ready; its fields are
  // latched on that edge, and req_ready stays low until that request has been committed.
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_on,
  input  logic [KEY_W-1:0]               req_key,
  input  logic [PERIOD_W-1:0]            req_period,
  output logic [NUM_VOICES*PERIOD_W-1:0] voice_period,
  output logic [NUM_VOICES*KEY_W-1:0]    voice_key,
  output logic [NUM_VOICES-1:0]          voice_active,
  output logic                           steal_pulse,
  output alloc_state_t                   dbg_state,
  output logic [NUM_VOICES*AGE_W-1:0]    dbg_age
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  alloc_state_t        state_q, state_d;
  idx_t                idx_q, idx_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                on_q, on_d;
  logic                match_found_q, match_found_d;
  idx_t                match_idx_q, match_idx_d;
  logic                free_found_q, free_found_d;
  idx_t                free_idx_q, free_idx_d;
  logic                old_found_q, old_found_d;
  idx_t                old_idx_q, old_idx_d;
  logic [AGE_W-1:0]    old_age_q, old_age_d;
  logic                steal_q, steal_d;
  idx_t                tgt;

  logic [NUM_VOICES-1:0] slot_active, slot_match, load_v, clear_v, age_inc_v;
  logic [AGE_W-1:0]      slot_age [NUM_VOICES];

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_slot
    voice_slot #(.KEY_W(KEY_W), .PERIOD_W(PERIOD_W), .AGE_W(AGE_W)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load_i    (load_v[v]),
      .clear_i   (clear_v[v]),
      .age_inc_i (age_inc_v[v]),
      .key_i     (key_q),
      .period_i  (period_q),
      .cmp_key_i (key_q),
      .active_o  (slot_active[v]),
      .key_o     (voice_key[v*KEY_W +: KEY_W]),
      .period_o  (voice_period[v*PERIOD_W +: PERIOD_W]),
      .age_o     (slot_age[v]),
      .match_o   (slot_match[v])
    );
    assign dbg_age[v*AGE_W +: AGE_W] = slot_age[v];
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    key_d         = key_q;
    period_d      = period_q;
    on_d          = on_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    steal_d       = 1'b0;
    load_v        = '0;
    clear_v       = '0;
    age_inc_v     = '0;
    tgt           = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          key_d         = req_key;
          period_d      = req_period;
          // A note-on with a zero period silences the key, exactly like a note-off.
          on_d          = req_on && (req_period != '0);
          idx_d         = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          old_found_d   = 1'b0;
          old_age_d     = '0;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        if (slot_match[idx_q] && !match_found_q) begin
          match_found_d = 1'b1;
          match_idx_d   = idx_q;
        end
        if (!slot_active[idx_q] && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        // Strict greater-than keeps the lowest index on equal ages.
        if (slot_active[idx_q] && (!old_found_q || (slot_age[idx_q] > old_age_q))) begin
          old_found_d = 1'b1;
          old_idx_d   = idx_q;
          old_age_d   = slot_age[idx_q];
        end
        if (idx_q == idx_t'(NUM_VOICES - 1)) state_d = COMMIT;
        else                                 idx_d   = idx_q + idx_t'(1);
      end
      COMMIT: begin
        state_d = IDLE;
        if (on_q) begin
          if (match_found_q)     tgt = match_idx_q;
          else if (free_found_q) tgt = free_idx_q;
          else                   tgt = old_idx_q;
          load_v[tgt] = 1'b1;
          age_inc_v   = ~(NUM_VOICES'(1) << tgt);
          steal_d     = !match_found_q && !free_found_q;
        end else if (match_found_q) begin
          clear_v[match_idx_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      key_q         <= '0;
      period_q      <= '0;
      on_q          <= 1'b0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      steal_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      key_q         <= key_d;
      period_q      <= period_d;
      on_q          <= on_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      steal_q       <= steal_d;
    end
  end

  assign req_ready    = (state_q == IDLE) && !reset;
  assign voice_active = slot_active;
  assign steal_pulse  = steal_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Shares a fixed pool of NUM_VOICES oscillator slots (triangle/noise generators) among a stream of note-on/note-off requests.
- Sits between the key/MIDI front end and the oscillator bank.
- Drives each oscillator's period (0 = silent) and keeps per-voice key and age state.
- Steals the oldest voice when the pool is full.

Parameters:
- NUM_VOICES, 4, number of oscillator slots (2..8).
- KEY_W, 7, key number width.
- PERIOD_W, 32, oscillator period width; matches the oscillator period input.
- AGE_W, 8, saturating age counter width per voice.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  allocator can accept a request.
- req_on  in  1  1 = note-on, 0 = note-off.
- req_key  in  KEY_W  key number.
- req_period  in  PERIOD_W  oscillator period for a note-on.
- voice_period  out  NUM_VOICES*PERIOD_W  per-voice period; slice v = voice v; 0 when inactive.
- voice_key  out  NUM_VOICES*KEY_W  key held by each voice.
- voice_active  out  NUM_VOICES  per-voice active flag.
- steal_pulse  out  1  one-cycle strobe when a commit steals a voice.

Behaviour:
- Reset (async, active-high):
  - voice_period, voice_key, voice_active, ages and steal_pulse go to 0; FSM goes to IDLE.
  - req_ready = 0 while reset is high.
  - Reset mid-SCAN abandons the request; no commit occurs.
- Handshake:
  - Transfer occurs on a rising edge where req_valid && req_ready.
  - req_key, req_on and req_period are latched on that edge.
  - req_ready = (state == IDLE) && !reset.
  - Inputs are don't-care when no transfer occurs.
- FSM IDLE -> SCAN -> COMMIT -> IDLE:
  - IDLE: wait for a transfer.
  - SCAN: index counter runs 0..NUM_VOICES-1, one voice per cycle. It records:
    - match: an active voice with key == latched key; lowest index wins.
    - free: the first inactive voice.
    - oldest: the active voice with the largest age; ties go to the lowest index.
  - COMMIT: one cycle; outputs update on the edge leaving COMMIT.
- Latency: transfer edge E0; SCAN edges E1..E_N; COMMIT edge E_{N+1}. Outputs and req_ready=1 are visible after E_{N+1}, i.e. N+2 cycles between transfers (6 for N=4).
- Note-on target selection, in priority order:
  - match exists: retrigger that voice (new period, age 0).
  - else free exists: use it (active=1, key, period, age 0).
  - else steal oldest: overwrite key and period, age 0; steal_pulse=1 for exactly the cycle after E_{N+1}.
- Ages on note-on commit: every other active voice increments its age, saturating at 2^AGE_W-1; inactive voices hold age 0.
- Note-off:
  - match: active=0, period=0, age=0; voice_key retains its value.
  - no match: no state change.
  - Ages of other voices are unchanged.
- Note-on with req_period == 0 is processed as a note-off for that key.
- Only one request is in flight at a time; no queueing. The requester holds req_valid until ready.

Decomposition:
- synth_pkg holds:
  - alloc_state_t enum {IDLE, SCAN, COMMIT};
  - default KEY_W, PERIOD_W, AGE_W constants.
- Sub-module voice_slot (one per voice) holds the active, key, period and age registers. Commands: load, clear, age_inc; it exposes a match compare.
- Top level holds the FSM, scan counter and selection registers.

Test Plan:
- Reset, then note-on key 60, period 1000 -> after 6 cycles: voice 0 active, period 1000, key 60; req_ready low for those cycles then high; steal_pulse stays 0.
- Note-on keys 60, 62, 64, 67 (periods 1000/900/800/700) -> voices 0..3 active in order; final ages 3,2,1,0.
- Note-on key 69, period 600 with the pool full -> voice 0 (oldest) reloads key 69 / period 600; steal_pulse high exactly 1 cycle; other ages saturate/increment correctly.
- Note-off key 62 -> voice 1 period 0, active 0. Then note-on key 71 -> lands on voice 1 (free wins over steal), no steal_pulse.
- Note-on key 64 again with period 500 -> retrigger: voice 2 period 500, age 0, no new voice used. Note-off key 99 (absent) -> no output change.
- Assert reset during SCAN of a note-on -> all outputs 0 immediately; after release, req_ready=1 and no voice is allocated.
